// File: rtl/jtag_tap_pkg.sv
// Shared types and constants for the oversampled JTAG TAP responder:
// TAP state encodings, IR opcodes and the next-state/opcode-decode helpers.
package jtag_tap_pkg;

  localparam int unsigned IR_WIDTH = 4;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = 4'b0010;
  localparam logic [IR_WIDTH-1:0] IR_DEBUG   = 4'b1000;
  localparam logic [IR_WIDTH-1:0] IR_BYPASS  = 4'b1111;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = 4'b0101;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SEL_IR     = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SEL_DR     = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_RTI        = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_TLR        = 4'hF
  } tap_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_DEBUG  = 2'd2
  } dr_sel_t;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TAP_TLR;
    case (s)
      TAP_TLR:        n = tms ? TAP_TLR       : TAP_RTI;
      TAP_RTI:        n = tms ? TAP_SEL_DR    : TAP_RTI;
      TAP_SEL_DR:     n = tms ? TAP_SEL_IR    : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   n = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   n = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   n = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  n = tms ? TAP_SEL_DR    : TAP_RTI;
      TAP_SEL_IR:     n = tms ? TAP_TLR       : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   n = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   n = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   n = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  n = tms ? TAP_SEL_DR    : TAP_RTI;
      default:        n = TAP_TLR;
    endcase
    return n;
  endfunction

  // Unknown opcodes fall back to bypass so the chain length stays defined.
  function automatic dr_sel_t decode_ir(input logic [IR_WIDTH-1:0] ir);
    dr_sel_t sel;
    case (ir)
      IR_IDCODE: sel = DR_IDCODE;
      IR_DEBUG:  sel = DR_DEBUG;
      IR_BYPASS: sel = DR_BYPASS;
      default:   sel = DR_BYPASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/jtag_tap_sampled_pin_sync.sv
// Synchronizes the JTAG pads into the system clock domain and derives
// single-cycle tck rise/fall events from the synchronized clock.
module jtag_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  output logic sync_tms,
  output logic sync_tdi,
  output logic rise,
  output logic fall
);

  // Index 0 is the pad-side stage; all three pins share one chain so tms/tdi
  // stay coherent with the tck edge they belong to.
  logic [SYNC_STAGES-1:0][2:0] chain;
  logic                        tck_d;
  logic                        sync_tck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      tck_d <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], {tck, tms, tdi}};
      tck_d <= chain[SYNC_STAGES-1][2];
    end
  end

  assign sync_tck = chain[SYNC_STAGES-1][2];
  assign sync_tms = chain[SYNC_STAGES-1][1];
  assign sync_tdi = chain[SYNC_STAGES-1][0];
  assign rise     = sync_tck & ~tck_d;
  assign fall     = ~sync_tck & tck_d;

endmodule

// File: rtl/jtag_tap_sampled.sv
// JTAG TAP responder clocked by wb_clk_i: 16-state TAP FSM, 4-bit IR,
// IDCODE/BYPASS data registers and a strobe interface to the debug chain.
module jtag_tap_sampled
  import jtag_tap_pkg::*;
#(
  parameter logic [31:0] IDCODE_VALUE = 32'h149511C3,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic wb_clk_i,
  input  logic wb_rst_n_i,
  input  logic tck_pad_i,
  input  logic tms_pad_i,
  input  logic tdi_pad_i,
  output logic tdo_pad_o,
  output logic tdo_oe_o,
  output logic test_logic_reset_o,
  output logic debug_select_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic update_dr_o,
  output logic debug_tdi_o,
  input  logic debug_tdo_i
);

  logic tms;
  logic tdi;
  logic rise;
  logic fall;

  jtag_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pin_sync (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n_i),
    .tck      (tck_pad_i),
    .tms      (tms_pad_i),
    .tdi      (tdi_pad_i),
    .sync_tms (tms),
    .sync_tdi (tdi),
    .rise     (rise),
    .fall     (fall)
  );

  tap_state_t          state;
  tap_state_t          state_next;
  logic [IR_WIDTH-1:0] ir;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [31:0]         idcode_dr;
  logic                bypass_dr;
  dr_sel_t             dr_sel;

  assign state_next = tap_next(state, tms);
  assign dr_sel     = decode_ir(ir);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state              <= TAP_TLR;
      ir                 <= IR_IDCODE;
      ir_shift           <= '0;
      idcode_dr          <= '0;
      bypass_dr          <= 1'b0;
      tdo_pad_o          <= 1'b0;
      tdo_oe_o           <= 1'b0;
      test_logic_reset_o <= 1'b1;
      debug_select_o     <= 1'b0;
      capture_dr_o       <= 1'b0;
      shift_dr_o         <= 1'b0;
      update_dr_o        <= 1'b0;
      debug_tdi_o        <= 1'b0;
    end else begin
      capture_dr_o <= 1'b0;
      shift_dr_o   <= 1'b0;
      update_dr_o  <= 1'b0;

      if (rise) begin
        state              <= state_next;
        test_logic_reset_o <= (state_next == TAP_TLR);

        case (state)
          TAP_CAPTURE_IR: ir_shift <= IR_CAPTURE;
          TAP_SHIFT_IR:   ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
          TAP_UPDATE_IR: begin
            ir             <= ir_shift;
            debug_select_o <= (ir_shift == IR_DEBUG);
          end
          TAP_CAPTURE_DR: begin
            case (dr_sel)
              DR_IDCODE: idcode_dr    <= IDCODE_VALUE;
              DR_DEBUG:  capture_dr_o <= 1'b1;
              default:   bypass_dr    <= 1'b0;
            endcase
          end
          TAP_SHIFT_DR: begin
            case (dr_sel)
              DR_IDCODE: idcode_dr <= {tdi, idcode_dr[31:1]};
              DR_DEBUG: begin
                shift_dr_o  <= 1'b1;
                debug_tdi_o <= tdi;
              end
              default:   bypass_dr <= tdi;
            endcase
          end
          TAP_UPDATE_DR: begin
            if (dr_sel == DR_DEBUG) update_dr_o <= 1'b1;
          end
          default: ;
        endcase

        // Clearing IR on entry (not just while resident) makes the five-tms=1
        // escape leave debug selection immediately.
        if (state_next == TAP_TLR) begin
          ir             <= IR_IDCODE;
          debug_select_o <= 1'b0;
        end
      end

      if (fall) begin
        tdo_oe_o <= (state == TAP_SHIFT_IR) || (state == TAP_SHIFT_DR);
        if (state == TAP_SHIFT_IR) begin
          tdo_pad_o <= ir_shift[0];
        end else if (state == TAP_SHIFT_DR) begin
          case (dr_sel)
            DR_IDCODE: tdo_pad_o <= idcode_dr[0];
            DR_DEBUG:  tdo_pad_o <= debug_tdo_i;
            default:   tdo_pad_o <= bypass_dr;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Directed bench for jtag_tap_sampled: a tck-level TAP model predicts every
// output, and literal values pin the IDCODE, IR capture and strobe counts.
module tb_jtag_tap_sampled;

  localparam logic [31:0] IDC = 32'h149511C3;

  // Model state indices in standard TAP diagram order.
  localparam int S_TLR = 0,  S_RTI = 1,  S_SDS = 2,  S_CDR = 3;
  localparam int S_SDR = 4,  S_E1D = 5,  S_PDR = 6,  S_E2D = 7;
  localparam int S_UDR = 8,  S_SIS = 9,  S_CIR = 10, S_SIR = 11;
  localparam int S_E1I = 12, S_PIR = 13, S_E2I = 14, S_UIR = 15;

  int nx0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nx1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  logic clk = 1'b0;
  logic rst_n;
  logic tck_pad, tms_pad, tdi_pad, dbg_tdo;
  logic tdo_pad_o, tdo_oe_o, test_logic_reset_o, debug_select_o;
  logic capture_dr_o, shift_dr_o, update_dr_o, debug_tdi_o;

  jtag_tap_sampled #(
    .IDCODE_VALUE(IDC),
    .SYNC_STAGES (2)
  ) dut (
    .wb_clk_i           (clk),
    .wb_rst_n_i         (rst_n),
    .tck_pad_i          (tck_pad),
    .tms_pad_i          (tms_pad),
    .tdi_pad_i          (tdi_pad),
    .tdo_pad_o          (tdo_pad_o),
    .tdo_oe_o           (tdo_oe_o),
    .test_logic_reset_o (test_logic_reset_o),
    .debug_select_o     (debug_select_o),
    .capture_dr_o       (capture_dr_o),
    .shift_dr_o         (shift_dr_o),
    .update_dr_o        (update_dr_o),
    .debug_tdi_o        (debug_tdi_o),
    .debug_tdo_i        (dbg_tdo)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int          m_st;
  logic [3:0]  m_ir, m_irsh;
  logic [31:0] m_dr;
  logic        m_byp, m_tdo, m_oe;
  int          exp_cap, exp_sh, exp_upd;
  logic        exp_dtdi;
  bit          settled;
  int          phase_id;
  int          tot_cap, tot_sh, tot_upd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_debug();
    return m_ir == 4'b1000;
  endfunction

  function automatic void model_reset();
    m_st = S_TLR; m_ir = 4'b0010; m_irsh = '0; m_dr = '0;
    m_byp = 1'b0; m_tdo = 1'b0; m_oe = 1'b0;
    exp_cap = 0; exp_sh = 0; exp_upd = 0; exp_dtdi = 1'b0;
  endfunction

  function automatic void model_rise(input bit tms, input bit tdi);
    exp_cap = 0; exp_sh = 0; exp_upd = 0;
    case (m_st)
      S_CIR: m_irsh = 4'b0101;
      S_SIR: m_irsh = {tdi, m_irsh[3:1]};
      S_UIR: m_ir = m_irsh;
      S_CDR: if (m_ir == 4'b0010) m_dr = IDC;
             else if (m_debug()) exp_cap = 1;
             else m_byp = 1'b0;
      S_SDR: if (m_ir == 4'b0010) m_dr = {tdi, m_dr[31:1]};
             else if (m_debug()) begin exp_sh = 1; exp_dtdi = tdi; end
             else m_byp = tdi;
      S_UDR: if (m_debug()) exp_upd = 1;
      default: ;
    endcase
    m_st = tms ? nx1[m_st] : nx0[m_st];
    if (m_st == S_TLR) m_ir = 4'b0010;
  endfunction

  function automatic void model_fall(input bit dtdo);
    exp_cap = 0; exp_sh = 0; exp_upd = 0;
    m_oe = (m_st == S_SIR) || (m_st == S_SDR);
    if (m_st == S_SIR) m_tdo = m_irsh[0];
    else if (m_st == S_SDR)
      m_tdo = (m_ir == 4'b0010) ? m_dr[0] : (m_debug() ? dtdo : m_byp);
  endfunction

  task automatic compare_loop();
    int   seen = -1;
    int   cap = 0, sh = 0, upd = 0;
    logic dt = 1'b0;
    forever begin
      @(negedge clk);
      if (phase_id != seen) begin
        seen = phase_id; cap = 0; sh = 0; upd = 0;
      end
      if (capture_dr_o === 1'b1) begin cap++; tot_cap++; end
      if (shift_dr_o === 1'b1) begin sh++; tot_sh++; dt = debug_tdi_o; end
      if (update_dr_o === 1'b1) begin upd++; tot_upd++; end
      if (settled) begin
        chk("tdo_oe", tdo_oe_o, m_oe);
        chk("tdo", tdo_pad_o, m_tdo);
        chk("test_logic_reset", test_logic_reset_o, m_st == S_TLR);
        chk("debug_select", debug_select_o, m_debug());
        chk("capture_pulses", cap, exp_cap);
        chk("shift_pulses", sh, exp_sh);
        chk("update_pulses", upd, exp_upd);
        if (exp_sh == 1) chk("debug_tdi", dt, exp_dtdi);
      end
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // tdo is sampled just before tck rises, as a JTAG initiator would.
  task automatic tck_cycle(input bit tms, input bit tdi, input bit dtdo, output bit tdo_s);
    tdo_s = tdo_pad_o;
    tms_pad = tms; tdi_pad = tdi; dbg_tdo = dtdo; tck_pad = 1'b1;
    model_rise(tms, tdi); phase_id++;
    wait_clk(4); settled = 1'b1; wait_clk(4); settled = 1'b0;
    tck_pad = 1'b0;
    model_fall(dtdo); phase_id++;
    wait_clk(4); settled = 1'b1; wait_clk(4); settled = 1'b0;
  endtask

  task automatic move(input int n, input logic [15:0] seq);
    bit t;
    for (int i = 0; i < n; i++) tck_cycle(seq[i], 1'b0, 1'b0, t);
  endtask

  task automatic scan(input int n, input logic [31:0] tdi_b, input logic [31:0] dtdo_b,
                      input bit last_tms, output logic [31:0] tdo_b);
    bit t;
    tdo_b = '0;
    for (int i = 0; i < n; i++) begin
      tck_cycle((i == n - 1) ? last_tms : 1'b0, tdi_b[i], dtdo_b[i], t);
      tdo_b[i] = t;
    end
  endtask

  initial begin
    logic [31:0] got;
    int c0, s0, u0;
    tck_pad = 1'b0; tms_pad = 1'b1; tdi_pad = 1'b0; dbg_tdo = 1'b0;
    rst_n = 1'b0; settled = 1'b0; phase_id = 0;
    tot_cap = 0; tot_sh = 0; tot_upd = 0;
    model_reset();
    fork compare_loop(); join_none
    wait_clk(3);
    chk("reset_tlr", test_logic_reset_o, 1);
    chk("reset_oe", tdo_oe_o, 0);
    chk("reset_tdo", tdo_pad_o, 0);
    chk("reset_dsel", debug_select_o, 0);
    chk("reset_strobes", {capture_dr_o, shift_dr_o, update_dr_o}, 0);
    rst_n = 1'b1;
    wait_clk(2);

    // 1: tms held high keeps the TAP parked in Test-Logic-Reset
    move(6, 16'h003F);
    chk("t1_tlr", test_logic_reset_o, 1);
    chk("t1_strobes", tot_cap + tot_sh + tot_upd, 0);

    // 2: IDCODE read, LSB first
    move(4, 16'h0002);
    scan(32, 32'h0, 32'h0, 1'b1, got);
    chk("t2_idcode", got, 32'h149511C3);
    move(2, 16'h0001);

    // 3: IR capture pattern, then bypass one-bit delay
    move(4, 16'h0003);
    scan(4, 32'hF, 32'h0, 1'b1, got);
    chk("t3_ir_capture", got, 32'h5);
    move(2, 16'h0001);
    move(3, 16'h0001);
    scan(4, 32'hD, 32'h0, 1'b1, got);
    chk("t3_bypass", got, 32'hA);
    move(2, 16'h0001);

    // 4: DEBUG opcode and strobe interface
    move(4, 16'h0003);
    scan(4, 32'h8, 32'h0, 1'b1, got);
    chk("t4_ir_capture", got, 32'h5);
    move(2, 16'h0001);
    chk("t4_dsel", debug_select_o, 1);
    c0 = tot_cap; s0 = tot_sh; u0 = tot_upd;
    move(3, 16'h0001);
    scan(8, 32'h5A, 32'hCA, 1'b1, got);
    chk("t4_debug_tdo", got, 32'h94);
    move(2, 16'h0001);
    chk("t4_capture_total", tot_cap - c0, 1);
    chk("t4_shift_total", tot_sh - s0, 8);
    chk("t4_update_total", tot_upd - u0, 1);

    // 5: escape from Pause-DR with five tms=1
    move(4, 16'h0005);
    move(5, 16'h001F);
    chk("t5_tlr", test_logic_reset_o, 1);
    chk("t5_dsel", debug_select_o, 0);
    move(4, 16'h0002);
    scan(32, 32'h0, 32'h0, 1'b1, got);
    chk("t5_idcode", got, 32'h149511C3);
    move(2, 16'h0001);

    // 6: reset mid Shift-IR
    move(4, 16'h0003);
    scan(2, 32'h3, 32'h0, 1'b0, got);
    chk("t6_oe_before", tdo_oe_o, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_oe", tdo_oe_o, 0);
    chk("t6_tdo", tdo_pad_o, 0);
    chk("t6_tlr", test_logic_reset_o, 1);
    chk("t6_dsel", debug_select_o, 0);
    chk("t6_strobes", {capture_dr_o, shift_dr_o, update_dr_o}, 0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
    move(4, 16'h0002);
    scan(32, 32'h0, 32'h0, 1'b1, got);
    chk("t6_idcode", got, 32'h149511C3);
    move(2, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jtag_tap_sampled.md
Name: jtag_tap_sampled

Overview:
- JTAG TAP responder: the device-side end of the tms/tck/tdi/tdo link driven by the simulation JTAG VPI initiator.
- Runs entirely in the system clock domain; oversamples the JTAG pads instead of clocking on tck.
- Implements the 16-state IEEE 1149.1 TAP FSM, a 4-bit IR, IDCODE and BYPASS data registers, and a strobe/shift interface to an external debug-unit scan chain.
- Sits in orpsoc_top between the JTAG pads and the debug interface.

Parameters:
IDCODE_VALUE  32'h149511C3  value loaded into the IDCODE DR on Capture-DR; bit 0 must be 1
SYNC_STAGES  2  synchronizer flops on tck/tms/tdi; legal range 2..3

Ports:
wb_clk_i  in  1  system clock; all logic is on the rising edge
wb_rst_n_i  in  1  asynchronous active-low reset
tck_pad_i  in  1  JTAG clock, asynchronous to wb_clk_i
tms_pad_i  in  1  JTAG mode select
tdi_pad_i  in  1  JTAG data in
tdo_pad_o  out  1  JTAG data out
tdo_oe_o  out  1  tdo drive enable
test_logic_reset_o  out  1  high while FSM is in Test-Logic-Reset
debug_select_o  out  1  IR holds the DEBUG opcode
capture_dr_o  out  1  one-cycle strobe
shift_dr_o  out  1  one-cycle strobe
update_dr_o  out  1  one-cycle strobe
debug_tdi_o  out  1  sampled tdi, valid with shift_dr_o
debug_tdo_i  in  1  debug chain serial output

Behaviour:
- Async reset: state = TLR; IR = IDCODE (4'b0010); all shift registers 0; tdo_pad_o = 0; tdo_oe_o = 0; all strobes 0; test_logic_reset_o = 1; debug_select_o = 0.
- Synchronization: tck, tms and tdi pass through the same SYNC_STAGES flops; one extra tck flop provides edge detection.
  - rise = sync_tck & ~tck_d; fall = ~sync_tck & tck_d.
  - tms and tdi are taken from the final sync stage in the rise cycle, so they are coherent with tck.
  - Pad-to-action latency is SYNC_STAGES+1 wb_clk cycles.
  - Legal only if tck high and low times are each at least SYNC_STAGES+2 wb_clk cycles; otherwise behaviour is undefined.
- On rise: the FSM advances per the standard tms table. Actions are keyed to the state current at that edge:
  - Capture-IR: ir_shift <= 4'b0101.
  - Shift-IR: ir_shift <= {tdi, ir_shift[3:1]}.
  - Update-IR: IR <= ir_shift.
  - Capture-DR:
    - IDCODE: dr <= IDCODE_VALUE.
    - BYPASS or any unknown opcode: bypass <= 0.
    - DEBUG: capture_dr_o pulses.
  - Shift-DR: the selected register shifts right with tdi entering at the MSB (bypass is 1 bit); DEBUG pulses shift_dr_o with debug_tdi_o = tdi.
  - Update-DR: DEBUG pulses update_dr_o.
  - TLR: IR <= IDCODE.
- Strobes are exactly one wb_clk cycle wide and are asserted only while debug_select_o = 1.
- On fall:
  - tdo_oe_o <= (state is Shift-IR or Shift-DR).
  - tdo_pad_o <= ir_shift[0] in Shift-IR.
  - In Shift-DR, tdo_pad_o <= LSB of the selected DR; for DEBUG, tdo_pad_o <= debug_tdo_i.
  - In any other state, tdo_pad_o holds its value.
- Opcodes: IDCODE 4'b0010, DEBUG 4'b1000, BYPASS 4'b1111. Every other opcode selects bypass.
- debug_select_o = (IR == DEBUG), registered. It changes only at Update-IR or on entry to TLR.
- Five consecutive rises with tms = 1 reach TLR from any state.
- tck glitches filtered by the synchronizer produce no action. Rise and fall can never occur in the same cycle.
- Reset asserted mid-shift: immediate return to reset values. No partial IR update.

Decomposition:
- jtag_tap_pkg holds:
  - 4-bit state encodings for all 16 TAP states;
  - opcode constants IR_IDCODE, IR_DEBUG, IR_BYPASS;
  - IR_WIDTH = 4 and the IR capture constant 4'b0101.
- Sub-module jtag_pin_sync: SYNC_STAGES synchronizer for {tck, tms, tdi} plus tck rise/fall detection. Reset value of all flops is 0.
- The FSM, IR and DR logic stay in jtag_tap_sampled.

Test Plan:
1. Reset, tck toggling every 8 wb_clk cycles, tms = 1 -> test_logic_reset_o = 1, tdo_oe_o = 0, debug_select_o = 0, no strobes.
2. Reset to Shift-DR (tms 0,1,0,0), then 32 tck with tdi = 0 -> tdo_pad_o serial LSB-first equals 0x149511C3; tdo_oe_o = 1 only during the shift.
3. Enter Shift-IR, shift in 4'b1111 -> captured bits out are 1,0,1,0. After Update-IR, a DR shift of tdi pattern 1,0,1,1 yields tdo 0,1,0,1 (one-bit delay).
4. Load IR 4'b1000 -> debug_select_o = 1. One Capture-DR, 8 Shift-DR and one Update-DR produce exactly 1 capture_dr_o, 8 shift_dr_o and 1 update_dr_o pulses. debug_tdi_o matches tdi, and tdo follows debug_tdo_i.
5. From Pause-DR with IR = DEBUG, five tms = 1 rises -> TLR, debug_select_o = 0, IR = IDCODE.
6. Assert wb_rst_n_i low mid Shift-IR after 2 bits -> all outputs at reset values in the same cycle. IR stays IDCODE, and a following IDCODE read still returns 0x149511C3.
